// File: rtl/usb_xfer_ctrl.sv
// usb_xfer_ctrl: sequences USB RX/TX transactions and arbitrates the shared data buffer
module usb_xfer_ctrl #(
  parameter int BUF_DEPTH = 64,
  parameter int TIMEOUT   = 1000
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           rx_packet_valid,
  input  logic [2:0]                     rx_packet,
  input  logic                           rx_transfer_active,
  input  logic                           rx_error,
  input  logic                           tx_transfer_active,
  input  logic                           tx_error,
  input  logic [$clog2(BUF_DEPTH+1)-1:0] buffer_occupancy,
  input  logic                           ahb_tx_req,
  input  logic [1:0]                     ahb_tx_type,
  input  logic                           ahb_clear_req,
  output logic                           tx_start,
  output logic [1:0]                     tx_packet,
  output logic                           d_mode,
  output logic [1:0]                     buffer_owner,
  output logic                           clear,
  output logic [4:0]                     status,
  output logic                           irq
);
  localparam int CW = $clog2(TIMEOUT);
  typedef enum logic [2:0] {IDLE, RX_WAIT, RX_ACTIVE, RX_DONE, TX_LAUNCH, TX_WAIT, TX_ACTIVE} state_t;
  state_t        r_state, w_state;
  logic [CW-1:0] r_cnt, w_cnt;
  logic          r_pend, w_pend;
  logic [1:0]    r_pend_type, w_pend_type, w_tx_packet, w_owner;
  logic          w_fail, w_irq, w_clear, w_in_set, w_tx_done;
  logic          w_out, w_in_tok, w_tmo, w_wait, w_flag_clr;
  assign w_out      = rx_packet_valid && rx_packet == 3'd1;
  assign w_in_tok   = rx_packet_valid && rx_packet == 3'd2;
  assign w_tmo      = r_cnt == CW'(TIMEOUT - 1);
  assign w_wait     = r_state == RX_WAIT || r_state == TX_WAIT;
  assign w_flag_clr = ahb_clear_req && r_state != RX_DONE;
  // the counter only runs while parked in a wait state; any transition restarts it
  assign w_cnt = (w_wait && w_state == r_state) ? (w_tmo ? r_cnt : r_cnt + 1'b1) : '0;
  always_comb begin
    w_state     = r_state;
    w_pend      = r_pend | ahb_tx_req;
    w_pend_type = ahb_tx_req ? ahb_tx_type : r_pend_type;
    w_tx_packet = '0;
    w_owner     = buffer_owner;
    w_fail      = 1'b0;
    w_irq       = 1'b0;
    w_clear     = ahb_clear_req;
    w_in_set    = 1'b0;
    w_tx_done   = 1'b0;
    case (r_state)
      IDLE:
        if (w_out) begin
          w_state = RX_WAIT;
          w_owner = 2'd1;
        end else if (w_in_tok) w_in_set = 1'b1;
        else if (ahb_tx_req || r_pend) begin
          w_state     = TX_LAUNCH;
          w_pend      = 1'b0;
          w_tx_packet = ahb_tx_req ? ahb_tx_type : r_pend_type;
          w_owner     = w_tx_packet == 2'd0 ? 2'd2 : buffer_owner;
        end
      RX_WAIT, RX_ACTIVE:
        if (rx_error) begin
          w_state = IDLE;
          w_clear = 1'b1;
          w_fail  = 1'b1;
          w_owner = 2'd0;
        end else if (r_state == RX_WAIT) begin
          if (rx_transfer_active) w_state = RX_ACTIVE;
          else if (w_tmo) begin
            w_state = IDLE;
            w_fail  = 1'b1;
            w_owner = 2'd0;
          end
        end else if (!rx_transfer_active) begin
          w_state = RX_DONE;
          w_owner = 2'd0;
          w_irq   = 1'b1;
        end
      RX_DONE:   if (buffer_occupancy == '0 || ahb_clear_req) w_state = IDLE;
      TX_LAUNCH: w_state = TX_WAIT;
      TX_WAIT, TX_ACTIVE:
        if (tx_error || (r_state == TX_WAIT && !tx_transfer_active && w_tmo)) begin
          w_state = IDLE;
          w_fail  = 1'b1;
          w_owner = 2'd0;
        end else if (r_state == TX_WAIT) begin
          if (tx_transfer_active) w_state = TX_ACTIVE;
        end else if (!tx_transfer_active) begin
          w_state   = IDLE;
          w_irq     = 1'b1;
          w_tx_done = 1'b1;
          w_owner   = 2'd0;
        end
      default: w_state = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_pend       <= 1'b0;
      r_pend_type  <= '0;
      tx_start     <= 1'b0;
      tx_packet    <= '0;
      d_mode       <= 1'b0;
      buffer_owner <= '0;
      clear        <= 1'b0;
      status       <= '0;
      irq          <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_cnt        <= w_cnt;
      r_pend       <= w_pend;
      r_pend_type  <= w_pend_type;
      tx_start     <= w_state == TX_LAUNCH;
      tx_packet    <= w_tx_packet;
      d_mode       <= w_state inside {TX_LAUNCH, TX_WAIT, TX_ACTIVE};
      buffer_owner <= w_owner;
      clear        <= w_clear;
      // sticky error: a new error beats a simultaneous clear request
      status       <= {w_in_set | (status[4] & ~w_flag_clr & ~w_tx_done),
                       w_fail | (status[3] & ~w_flag_clr),
                       (w_state inside {TX_LAUNCH, TX_WAIT, TX_ACTIVE}) | w_pend,
                       w_state inside {RX_WAIT, RX_ACTIVE},
                       w_state == RX_DONE};
      irq          <= w_irq | w_fail;
    end
  end
endmodule
